muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide sequencer beside the EX-stage ALU. It executes MULT/MULTU/DIV/DIVU on the forwarded EX operands over 34 cycles and owns the architectural HI/LO registers. It raises a stall interlock so the hazard logic freezes IF/ID/EX when a dependent instruction reaches EX before the result is ready. The main ALU stays single-cycle; this block only sequences the long-latency operations and arbitrates HI/LO access.

## Interface
- WIDTH, 32, operand and HI/LO width; the count runs WIDTH iterations.
- clk  in  1  clock. All state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX holds a mul/div instruction; sampled only in IDLE.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
- operandA  in  WIDTH  forwarded rs value (post Forward-A mux).
- operandB  in  WIDTH  forwarded rt value (post Forward-B mux).
- flush  in  1  EX is being flushed; aborts any operation.
- mf_req  in  1  EX holds MFHI or MFLO.
- mthi, mtlo  in  1  EX holds MTHI or MTLO.
- mt_data  in  WIDTH  write data for MTHI/MTLO.
- hi, lo  out  WIDTH  architectural HI/LO, registered.
- busy  out  1  registered; high in every non-IDLE state.
- stall  out  1  combinational: busy & (start | mf_req | mthi | mtlo).
- done  out  1  registered one-cycle pulse when HI/LO take a new result.

## Operation
- **IDLE**
  - start & !flush: latch op, the operand magnitudes (abs for signed ops), the result signs and the divide-by-zero flag; clear the iteration counter; go to CALC.
  - Otherwise: mthi writes hi, and mtlo writes lo, from mt_data. mthi and mtlo may both be high; both then write.
  - start has priority over mthi/mtlo; they are mutually exclusive by decode.
- **CALC** (WIDTH cycles)
  - Multiply: shift-add, 2·WIDTH-bit product register.
  - Divide: restoring division, one quotient bit per cycle.
  - The counter increments each cycle. At count WIDTH-1, go to FIX.
- **FIX** (1 cycle)
  - Sign correction:
    - MULT product is negated when signA ^ signB.
    - DIV quotient is negated when signA ^ signB.
    - DIV remainder is negated when signA.
  - Write hi/lo: multiply gives hi = upper word, lo = lower word; divide gives lo = quotient, hi = remainder. Pulse done. Go to IDLE.
- **Divide by zero** (DIV or DIVU): lo = all-ones, hi = operandA unmodified, with no sign fix. Latency is unchanged.
- **DIV 0x80000000 / 0xFFFFFFFF**: lo = 0x80000000, hi = 0. No trap.
- **flush** in any state: return to IDLE next edge. hi/lo unchanged, done not pulsed.
- **Requests while busy**: start, mf_req, mthi and mtlo are not consumed. stall holds them in EX until busy falls.
- Arithmetic is modulo 2^WIDTH per word. Nothing is reported on overflow.

## Timing
- **Reset**: state IDLE, hi = lo = 0, busy = 0, done = 0. Counter and working registers are cleared.
- **Latency**: start accepted at edge E0.
  - busy is high in cycles E0+1 … E0+33.
  - hi/lo are updated and done is high after edge E0+33.
  - busy is low after edge E0+34.
  - Total: 34 cycles from acceptance to result.
- **Back-to-back**: a new start is accepted at edge E0+34 at the earliest. The instruction after a mul/div that is not dependent does not stall.
- **MFHI/MFLO**: in the cycle busy is low, hi/lo already hold the new result. stall drops combinationally the same cycle.
- **Reset mid-operation**: rst overrides flush and all other inputs. It returns the block to the reset values on that edge.
- **Simultaneous flush & start in IDLE**: flush wins; the block stays in IDLE.

## Test plan
- **Unsigned multiply**: MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 34 cycles, hi=0xFFFFFFFE, lo=0x00000001, one done pulse, busy high for exactly 33 cycles.
- **Signed multiply**: MULT 0xFFFFFFFD × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- **Signed divide**: DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- **Divide by zero**: DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100 after 34 cycles.
- **Flush**: flush asserted 10 cycles into MULT 7 × 9 -> busy low next cycle, hi/lo keep their prior values, done never pulses.
- **Interlock**: MFLO issued the cycle after start -> stall high until busy falls, and lo then equals the new product. MTHI 0x1234 while busy is ignored until busy is low, then hi=0x1234.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative 32-cycle multiply/divide unit beside the EX-stage ALU.
// Owns HI/LO and raises a stall interlock while an operation is in flight.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operandA_i,
  input  logic [WIDTH-1:0] operandB_i,
  input  logic             flush_i,
  input  logic             mf_req_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] mt_data_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               isDiv_q, isDiv_d;
  logic               signA_q, signA_d;
  logic               signB_q, signB_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   aRaw_q, aRaw_d;
  logic [WIDTH-1:0]   oper_q, oper_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               opSigned;
  logic               newSignA, newSignB;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     addSum;
  logic [2*WIDTH-1:0] mulStep;
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [WIDTH-1:0]   divDiff;
  logic [2*WIDTH-1:0] divStep;
  logic [2*WIDTH-1:0] prodNeg;
  logic [WIDTH-1:0]   quoNeg, remNeg;

  assign opSigned = ~op_i[0];
  assign newSignA = opSigned & operandA_i[WIDTH-1];
  assign newSignB = opSigned & operandB_i[WIDTH-1];
  assign magA     = newSignA ? -operandA_i : operandA_i;
  assign magB     = newSignB ? -operandB_i : operandB_i;

  // Multiply: upper half accumulates the multiplicand, lower half holds the remaining multiplier bits.
  assign addSum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, oper_q};
  assign mulStep = prod_q[0] ? {addSum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign divShift = prod_q[2*WIDTH-1:WIDTH-1];
  assign divGe    = divShift >= {1'b0, oper_q};
  assign divDiff  = divShift[WIDTH-1:0] - oper_q;
  assign divStep  = divGe ? {divDiff, prod_q[WIDTH-2:0], 1'b1}
                          : {divShift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

  assign prodNeg = -prod_q;
  assign quoNeg  = -prod_q[WIDTH-1:0];
  assign remNeg  = -prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    isDiv_d   = isDiv_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    divZero_d = divZero_q;
    aRaw_d    = aRaw_q;
    oper_d    = oper_q;
    prod_d    = prod_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          isDiv_d   = op_i[1];
          signA_d   = newSignA;
          signB_d   = newSignB;
          divZero_d = op_i[1] & (operandB_i == '0);
          aRaw_d    = operandA_i;
          oper_d    = op_i[1] ? magB : magA;
          prod_d    = {{WIDTH{1'b0}}, (op_i[1] ? magA : magB)};
          count_d   = '0;
          state_d   = CALC;
        end else begin
          if (mthi_i) hi_d = mt_data_i;
          if (mtlo_i) lo_d = mt_data_i;
        end
      end
      CALC: begin
        prod_d  = isDiv_q ? divStep : mulStep;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (!isDiv_q) begin
          {hi_d, lo_d} = (signA_q ^ signB_q) ? prodNeg : prod_q;
        end else if (divZero_q) begin
          lo_d = '1;
          hi_d = aRaw_q;
        end else begin
          lo_d = (signA_q ^ signB_q) ? quoNeg : prod_q[WIDTH-1:0];
          hi_d = signA_q ? remNeg : prod_q[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush kills whatever EX holds, including a start or an MTHI/MTLO this cycle.
    if (flush_i) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      prod_d  = prod_q;
      count_d = count_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      isDiv_q   <= 1'b0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      divZero_q <= 1'b0;
      aRaw_q    <= '0;
      oper_q    <= '0;
      prod_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      isDiv_q   <= isDiv_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      divZero_q <= divZero_d;
      aRaw_q    <= aRaw_d;
      oper_q    <= oper_d;
      prod_q    <= prod_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign stall_o = busy_q & (start_i | mf_req_i | mthi_i | mtlo_i);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of mul/div results plus
// hand-written sequences for flush, reset, interlock and HI/LO moves.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush, mfReq, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, mtData;
  logic [31:0] hi, lo;
  logic        busy, stall, done;

  int testsRun = 0;
  int testsFailed = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .operandA_i(a), .operandB_i(b), .flush_i(flush),
    .mf_req_i(mfReq), .mthi_i(mthi), .mtlo_i(mtlo), .mt_data_i(mtData),
    .hi_o(hi), .lo_o(lo), .busy_o(busy), .stall_o(stall), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE and follow it until busy falls; caller sits #1 after an edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               output int busyCycles, output int dones);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    busyCycles = 0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) dones++;
      if (!busy) break;
      busyCycles++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int bc, dn, bad, cyc;
    vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{2'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[5]  = '{2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8]  = '{2'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[9]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

    rst = 1'b1; start = 1'b0; flush = 1'b0; mfReq = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; a = '0; b = '0; mtData = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    checkOutput("reset done", {31'b0, done}, 32'h0);
    rst = 1'b0;

    // MTHI and MTLO together in IDLE both write.
    mthi = 1'b1; mtlo = 1'b1; mtData = 32'hA5A50001;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checkOutput("mthi+mtlo hi", hi, 32'hA5A50001);
    checkOutput("mthi+mtlo lo", lo, 32'hA5A50001);

    // Each op is launched the cycle busy falls, so these also run back-to-back.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, bc, dn);
      checkOutput($sformatf("vec%0d busy cycles", i), bc, 33);
      checkOutput($sformatf("vec%0d done pulses", i), dn, 1);
      checkOutput($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      checkOutput($sformatf("vec%0d lo", i), lo, vecs[i].lo);
    end

    // Flush ten cycles into MULT 7 x 9: result discarded, no done.
    start = 1'b1; op = 2'd0; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush busy", {31'b0, busy}, 32'h0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    checkOutput("flush done pulses", dn, 0);
    checkOutput("flush hi kept", hi, 32'h0000000F);
    checkOutput("flush lo kept", lo, 32'h0FFFFFFF);

    // Flush and start together in IDLE: start is dropped.
    start = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("flush+start busy", {31'b0, busy}, 32'h0);

    // MFLO the cycle after start stalls until busy falls, then sees the product.
    start = 1'b1; op = 2'd0; a = 32'hFFFFFFFD; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; mfReq = 1'b1;
    bad = 0; cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      if (!stall) bad++;
      cyc++;
      @(posedge clk); #1;
    end
    checkOutput("mflo stall gaps", bad, 0);
    checkOutput("mflo stall cycles", cyc, 33);
    checkOutput("mflo stall released", {31'b0, stall}, 32'h0);
    checkOutput("mflo lo", lo, 32'hFFFFFFF1);
    mfReq = 1'b0;

    // MTHI while busy is held off; it lands once busy falls.
    start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b1; mtData = 32'h00001234;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      if (!stall) bad++;
      if (hi !== 32'hFFFFFFFF) bad++;
      @(posedge clk); #1;
    end
    checkOutput("mthi held while busy", bad, 0);
    checkOutput("mthi result hi", hi, 32'h0);
    checkOutput("mthi result lo", lo, 32'd12);
    @(posedge clk); #1;
    mthi = 1'b0;
    checkOutput("mthi applied hi", hi, 32'h00001234);
    checkOutput("mthi applied lo", lo, 32'd12);

    // Reset mid-operation wins over flush and clears HI/LO.
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    checkOutput("midop reset hi", hi, 32'h0);
    checkOutput("midop reset lo", lo, 32'h0);
    checkOutput("midop reset busy", {31'b0, busy}, 32'h0);
    checkOutput("midop reset done", {31'b0, done}, 32'h0);

    applyStimulus(2'd2, 32'hFFFFFF9C, 32'd7, bc, dn);
    checkOutput("post-reset busy cycles", bc, 33);
    checkOutput("post-reset hi", hi, 32'hFFFFFFFE);
    checkOutput("post-reset lo", lo, 32'hFFFFFFF2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
